// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path (uart_tx_buffer, uart_tx).
//   - ST_*       : launch FSM state encoding used by uart_tx_buffer
//   - DATA_W_DEF : default byte width, matches the uart_tx data port
//   - PARITY_*   : parity_mode encodings understood by uart_tx
// No ports; import with "import uart_pkg::*;".
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_W_DEF = 8;

   typedef logic [1:0] fsm_state_t;
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_LAUNCH    = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;

   typedef logic [1:0] parity_mode_t;
   localparam logic [1:0] PARITY_ODD   = 2'b11;
   localparam logic [1:0] PARITY_EVEN  = 2'b10;
   localparam logic [1:0] PARITY_MARK  = 2'b01;
   localparam logic [1:0] PARITY_SPACE = 2'b00;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO of 2**DEPTH_LOG2 entries with a registered read port.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   flush          : synchronous clear of pointers and overflow; wins over
//                    any concurrent write or read
//   wr_en, wr_data : enqueue request and data (dropped when full)
//   rd_en          : pop head; head is copied into rd_data on the same edge
//   rd_data        : last popped entry, held until the next pop (reset 0)
//   full, empty    : occupancy flags derived from the pointers
//   level          : occupancy, wr_ptr - rd_ptr
//   overflow       : sticky, set by a write attempt while full
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int DATA_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rd_en,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PTR_W = DEPTH_LOG2 + 1;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              overflow_q, overflow_d;
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              do_wr;
   logic              do_rd;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                  (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
   assign level = wr_ptr_q - rd_ptr_q;

   assign do_wr = wr_en && !full  && !flush;
   assign do_rd = rd_en && !empty && !flush;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         overflow_d = 1'b0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (wr_en && full) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage array has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
   end

   // Registered read: a pop never targets the slot being written, because
   // a pop needs !empty and a write needs !full.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (do_rd) begin
         rd_data_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
      end
   end

   assign rd_data  = rd_data_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// uart_tx_buffer
// Byte FIFO plus launch FSM placed directly upstream of uart_tx. The host
// writes at full clock rate; the FSM hands bytes to uart_tx one at a time
// over its data/send/ready handshake.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wr_data, wr_en  : host enqueue
//   flush           : clear the FIFO (an in-flight byte still completes)
//   full, empty     : FIFO occupancy flags
//   level           : FIFO occupancy
//   overflow        : sticky write-while-full flag, cleared by rst/flush
//   idle            : registered (FIFO empty && FSM in IDLE)
//   tx_ready        : uart_tx ready (high when the transmitter is idle)
//   tx_send         : registered send strobe to uart_tx
//   tx_data         : registered byte to uart_tx, held for the whole frame
//   low_wm          : (UART_TXBUF_WATERMARK_EN only) registered refill
//                     request, high when level <= LOW_WM
// Build option: define UART_TXBUF_WATERMARK_EN to add LOW_WM and low_wm.
// ---------------------------------------------------------------------------
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int DATA_W     = DATA_W_DEF
`ifdef UART_TXBUF_WATERMARK_EN
   ,
   parameter int LOW_WM     = 2
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  wr_en,
   input  logic                  flush,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic                  idle,
`ifdef UART_TXBUF_WATERMARK_EN
   output logic                  low_wm,
`endif
   input  logic                  tx_ready,
   output logic                  tx_send,
   output logic [DATA_W-1:0]     tx_data
);

   logic [1:0] state_q, state_d;
   logic       send_q;
   logic       idle_q;
   logic       pop;
   logic       fifo_empty;

   // Pop only from IDLE; flush suppresses the pop so a cleared FIFO
   // never launches its old head.
   assign pop = (state_q == ST_IDLE) && !fifo_empty && tx_ready && !flush;

   sync_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (DATA_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (tx_data),
      .full     (full),
      .empty    (fifo_empty),
      .level    (level),
      .overflow (overflow)
   );

   assign empty = fifo_empty;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (pop)       state_d = ST_LAUNCH;
         // uart_tx drops ready once it has taken the byte.
         ST_LAUNCH:    if (!tx_ready) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (tx_ready)  state_d = ST_IDLE;
         default:                     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         send_q  <= 1'b0;
         idle_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         // Send tracks the LAUNCH state exactly, so it is high for the
         // whole LAUNCH residency and falls on the edge into WAIT_DONE.
         send_q  <= (state_d == ST_LAUNCH);
         idle_q  <= fifo_empty && (state_q == ST_IDLE);
      end
   end

   assign tx_send = send_q;
   assign idle    = idle_q;

`ifdef UART_TXBUF_WATERMARK_EN
   logic low_wm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         low_wm_q <= 1'b1;
      end else begin
         low_wm_q <= (32'(level) <= LOW_WM);
      end
   end

   assign low_wm = low_wm_q;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffer
// Directed bench for uart_tx_buffer (DEPTH_LOG2=4, DATA_W=8). tx_ready is
// driven directly by the stimulus to play the role of uart_tx.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffer;

   logic       clk;
   logic       rst;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       flush;
   logic       full;
   logic       empty;
   logic [4:0] level;
   logic       overflow;
   logic       idle;
   logic       tx_ready;
   logic       tx_send;
   logic [7:0] tx_data;
`ifdef UART_TXBUF_WATERMARK_EN
   logic       low_wm;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   uart_tx_buffer #(
      .DEPTH_LOG2 (4),
      .DATA_W     (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .flush    (flush),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow),
      .idle     (idle),
`ifdef UART_TXBUF_WATERMARK_EN
      .low_wm   (low_wm),
`endif
      .tx_ready (tx_ready),
      .tx_send  (tx_send),
      .tx_data  (tx_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Precondition: FSM in IDLE, FIFO non-empty. Runs one full handshake
   // and leaves the FSM back in IDLE with tx_ready high.
   task automatic launch_byte(input string tag, input logic [7:0] exp);
      tx_ready = 1'b1;
      tick();
      check({tag, "_send"}, 32'(tx_send), 32'd1);
      check({tag, "_data"}, 32'(tx_data), 32'(exp));
      tx_ready = 1'b0;
      tick();
      check({tag, "_send_low"}, 32'(tx_send), 32'd0);
      tx_ready = 1'b1;
      tick();
   endtask

   initial begin
      rst      = 1'b1;
      wr_data  = 8'h00;
      wr_en    = 1'b0;
      flush    = 1'b0;
      tx_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // ---- reset state
      check("rst_full",     32'(full),     32'd0);
      check("rst_empty",    32'(empty),    32'd1);
      check("rst_level",    32'(level),    32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_idle",     32'(idle),     32'd1);
      check("rst_tx_send",  32'(tx_send),  32'd0);
      check("rst_tx_data",  32'(tx_data),  32'd0);

      // ---- 1: single byte, one cycle write-to-launch latency
      wr_data = 8'hAA; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      check("t1_level1",  32'(level),   32'd1);
      check("t1_nosend",  32'(tx_send), 32'd0);
      tick();
      check("t1_send",    32'(tx_send), 32'd1);
      check("t1_data",    32'(tx_data), 32'hAA);
      check("t1_level0",  32'(level),   32'd0);
      check("t1_busy",    32'(idle),    32'd0);
      tick();
      check("t1_hold",    32'(tx_send), 32'd1);
      tx_ready = 1'b0;
      tick();
      check("t1_accept",  32'(tx_send), 32'd0);
      check("t1_data_w",  32'(tx_data), 32'hAA);
      tick();
      check("t1_wait",    32'(tx_send), 32'd0);
      tx_ready = 1'b1;
      tick();
      tick();
      check("t1_idle",    32'(idle),    32'd1);
      check("t1_end",     32'(tx_send), 32'd0);

      // ---- 2: fill to full while transmitter busy, then overflow
      tx_ready = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         wr_data = 8'(i); wr_en = 1'b1;
         tick();
      end
      check("t2_full",     32'(full),     32'd1);
      check("t2_level16",  32'(level),    32'd16);
      check("t2_no_ovf",   32'(overflow), 32'd0);
      wr_data = 8'h11;
      tick();
      wr_en = 1'b0;
      check("t2_ovf",      32'(overflow), 32'd1);
      check("t2_level",    32'(level),    32'd16);
      check("t2_nosend",   32'(tx_send),  32'd0);
      for (int i = 1; i <= 16; i++) begin
         launch_byte($sformatf("t2_b%0d", i), 8'(i));
      end
      check("t2_empty",    32'(empty),    32'd1);
      tick();
      check("t2_no11",     32'(tx_data),  32'h10);
      check("t2_quiet",    32'(tx_send),  32'd0);
      check("t2_ovf_kept", 32'(overflow), 32'd1);

      // ---- 3: write during pop, ordered drain 55, AA, 0F
      wr_data = 8'h55; wr_en = 1'b1;
      tick();
      wr_data = 8'hAA;
      tick();
      wr_en = 1'b0;
      check("t3_level_wp", 32'(level),   32'd1);
      check("t3_send55",   32'(tx_send), 32'd1);
      check("t3_data55",   32'(tx_data), 32'h55);
      wr_data = 8'h0F; wr_en = 1'b1; tx_ready = 1'b0;
      tick();
      wr_en = 1'b0;
      check("t3_accept",   32'(tx_send), 32'd0);
      check("t3_level2",   32'(level),   32'd2);
      tx_ready = 1'b1;
      tick();
      launch_byte("t3_AA", 8'hAA);
      launch_byte("t3_0F", 8'h0F);
      check("t3_empty",    32'(empty),   32'd1);
      tick();
      check("t3_quiet",    32'(tx_send), 32'd0);
      check("t3_idle",     32'(idle),    32'd1);

      // ---- 4: flush while 3C is in WAIT_DONE with 5 queued
      wr_data = 8'h3C; wr_en = 1'b1;
      tick();
      wr_data = 8'hA1;
      tick();
      tx_ready = 1'b0;
      wr_data = 8'hA2;
      tick();
      wr_data = 8'hA3; tick();
      wr_data = 8'hA4; tick();
      wr_data = 8'hA5; tick();
      wr_en = 1'b0;
      check("t4_level5",   32'(level),    32'd5);
      check("t4_wait",     32'(tx_send),  32'd0);
      check("t4_data",     32'(tx_data),  32'h3C);
      check("t4_ovf_pre",  32'(overflow), 32'd1);
      flush = 1'b1; wr_data = 8'hEE; wr_en = 1'b1;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      check("t4_level0",   32'(level),    32'd0);
      check("t4_empty",    32'(empty),    32'd1);
      check("t4_ovf_clr",  32'(overflow), 32'd0);
      check("t4_data_hold",32'(tx_data),  32'h3C);
      tx_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t4_nosend%0d", i), 32'(tx_send), 32'd0);
      end
      check("t4_idle",     32'(idle),     32'd1);
      check("t4_data_end", 32'(tx_data),  32'h3C);

      // ---- 5: reset during LAUNCH
      wr_data = 8'h77; wr_en = 1'b1;
      tick();
      wr_data = 8'h78;
      tick();
      wr_en = 1'b0;
      check("t5_send",     32'(tx_send), 32'd1);
      check("t5_data",     32'(tx_data), 32'h77);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_send0",    32'(tx_send), 32'd0);
      check("t5_empty",    32'(empty),   32'd1);
      check("t5_level",    32'(level),   32'd0);
      check("t5_data0",    32'(tx_data), 32'd0);
      check("t5_idle",     32'(idle),    32'd1);
      wr_data = 8'h99; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      tick();
      check("t5_relaunch", 32'(tx_send), 32'd1);
      check("t5_data99",   32'(tx_data), 32'h99);
      tx_ready = 1'b0;
      tick();
      tx_ready = 1'b1;
      tick();

`ifdef UART_TXBUF_WATERMARK_EN
      // ---- 6: low watermark (LOW_WM=2), registered one cycle behind level
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_wm",   32'(low_wm), 32'd1);
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_data = 8'hC1 + 8'(i); wr_en = 1'b1;
         tick();
      end
      wr_en = 1'b0;
      check("t6_level4",   32'(level),  32'd4);
      check("t6_wm_l4",    32'(low_wm), 32'd0);
      tx_ready = 1'b1;
      tick();
      check("t6_wm_l3",    32'(low_wm), 32'd0);
      tx_ready = 1'b0;
      tick();
      check("t6_wm_l3b",   32'(low_wm), 32'd0);
      tx_ready = 1'b1;
      tick();
      tick();
      check("t6_level2",   32'(level),  32'd2);
      check("t6_wm_lag",   32'(low_wm), 32'd0);
      tx_ready = 1'b0;
      tick();
      check("t6_wm_rise",  32'(low_wm), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte FIFO plus launch FSM that sits directly upstream of uart_tx.
- Accepts bytes from the host side at full clock rate and stores them.
- Feeds them one at a time into uart_tx through its data/send/ready handshake, so the host never waits on the serial line.
- Drains autonomously; configuration inputs of uart_tx (size, parity, stop) are not touched by this block.

Parameters:
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries (default 16)
- DATA_W, 8, byte width; matches uart_tx data port

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr_data  input  DATA_W  byte to enqueue
- wr_en  input  1  enqueue wr_data this cycle
- flush  input  1  synchronous FIFO clear; does not abort a byte already handed to uart_tx
- full  output  1  FIFO holds 2**DEPTH_LOG2 entries
- empty  output  1  FIFO holds 0 entries
- level  output  DEPTH_LOG2+1  current FIFO occupancy
- overflow  output  1  sticky: write attempted while full; cleared by rst or flush
- idle  output  1  FIFO empty and FSM in IDLE (line quiet after current frame)
- tx_ready  input  1  ready from uart_tx (high when transmitter idle)
- tx_send  output  1  send strobe to uart_tx
- tx_data  output  DATA_W  byte to uart_tx, registered

Behaviour:
- Reset values: full=0, empty=1, level=0, overflow=0, idle=1, tx_send=0, tx_data=0; rd/wr pointers=0; FSM=IDLE.
- FIFO pointers are DEPTH_LOG2+1 bits wide with MSB wrap flag.
  - full when the low bits match and the MSBs differ; empty when the pointers are equal.
  - level = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1).
- Write: wr_en && !full stores the byte and advances wr_ptr. wr_en && full drops the byte and sets overflow.
- Pop: happens only on the FSM transition IDLE->LAUNCH. The head entry is copied into tx_data and rd_ptr advances in the same cycle.
- Simultaneous write and pop: both take effect and level is unchanged. A write into an empty FIFO is not visible to the FSM until the next cycle (1-cycle minimum latency wr_en -> LAUNCH).
- FSM states:
  - IDLE: if !empty && tx_ready, pop, then go to LAUNCH.
  - LAUNCH: tx_send=1 and tx_data held. Stay until tx_ready samples 0 (uart_tx accepted the byte), then go to WAIT_DONE with tx_send=0 that cycle.
  - WAIT_DONE: tx_send=0 and tx_data held. When tx_ready samples 1, go to IDLE.
- tx_send is registered and asserted for at least one full cycle.
- tx_data stays stable from LAUNCH entry through WAIT_DONE exit.
- Back-to-back bytes: after WAIT_DONE->IDLE, the next pop occurs in the first IDLE cycle, giving 2 cycles of FSM overhead between frames.
- flush:
  - Same cycle: pointers reset, empty=1, level=0, overflow=0.
  - A concurrent wr_en is ignored.
  - The FSM is not reset; an in-flight byte completes normally.
  - If flush and the IDLE pop coincide, flush wins and no pop occurs.
- rst mid-frame: the FSM returns to IDLE and tx_send drops immediately. uart_tx is reset by the same rst, so no partial-frame recovery is needed.
- idle = empty && state==IDLE, registered.

Optional Feature:
- Macro UART_TXBUF_WATERMARK_EN.
- Defined:
  - Adds parameter LOW_WM (default 2) and output port low_wm (1 bit).
  - low_wm is registered and high when level <= LOW_WM; reset value 1.
  - Used as a refill request to the host.
- Undefined: port and parameter are absent; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (ST_IDLE=2'd0, ST_LAUNCH=2'd1, ST_WAIT_DONE=2'd2)
  - DATA_W default
  - parity_mode encodings shared with uart_tx (11 odd, 10 even, 01 mark, 00 space)
- One natural sub-module: sync_fifo, with generic DEPTH_LOG2/DATA_W, pointer logic, full/empty/level/overflow, and a flush port. The FSM stays in uart_tx_buffer.

Test Plan:
1. Reset, then write 8'hAA with the tx_ready model idle -> level 1 -> LAUNCH next cycle, tx_data=8'hAA, tx_send held until model drops tx_ready; idle returns after model raises tx_ready.
2. Burst-write 8'h01..8'h10 (16 bytes) with the model busy -> full=1, level=16. A 17th write (8'h11) -> overflow=1, 8'h11 never appears on tx_data.
3. Drain a 3-byte FIFO against the real uart_tx (data_size=1, parity_en=1, parity_mode=11, stop=0) -> tx line carries 8'h55, 8'hAA, 8'h0F in order with odd parity; exactly one tx_send assertion per byte.
4. flush while byte 8'h3C is in WAIT_DONE and 5 bytes are queued -> 8'h3C frame completes, level=0, no further tx_send, overflow cleared.
5. Assert rst during LAUNCH -> next cycle tx_send=0, state IDLE, empty=1, tx_data=0.
6. (UART_TXBUF_WATERMARK_EN) Fill 4 bytes and drain with LOW_WM=2 -> low_wm=0 at level 3..4, rises the cycle after level reaches 2.
